// File: rtl/inv_mix_column_iter.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a shared
// GF(2^8) engine, valid/ready on both sides, result held until accepted.
module inv_mix_column_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] st;
  logic [1:0]   col;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Packs {09*b, 0b*b, 0d*b, 0e*b} from one shared xtime chain.
  function automatic logic [31:0] muls(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ b, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ x4 ^ x2};
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [31:0] m0, m1, m2, m3;
    m0 = muls(c[31:24]);
    m1 = muls(c[23:16]);
    m2 = muls(c[15:8]);
    m3 = muls(c[7:0]);
    return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
            m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
            m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
            m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
  endfunction

  always_comb begin
    col_in = st[127:96];
    unique case (col)
      2'd0: col_in = st[127:96];
      2'd1: col_in = st[95:64];
      2'd2: col_in = st[63:32];
      2'd3: col_in = st[31:0];
    endcase
  end

  assign col_out = inv_col(col_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            st  <= in_data;
            col <= '0;
          end
        end
        BUSY: begin
          unique case (col)
            2'd0: st[127:96] <= col_out;
            2'd1: st[95:64]  <= col_out;
            2'd2: st[63:32]  <= col_out;
            2'd3: st[31:0]   <= col_out;
          endcase
          col <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        if (col == 2'd3) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_data = st;

endmodule

// File: tb/tb_inv_mix_column_iter.sv
// Scoreboard bench for inv_mix_column_iter: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_inv_mix_column_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  inv_mix_column_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [127:0]  exp_q[$];
  int            acc_q[$];
  int            acc_log[$];
  logic [7:0]    fwd_k[4];
  logic [7:0]    inv_k[4];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = '0;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product per column; coefficient for (row i, col j) is k[(j-i) mod 4].
  function automatic logic [127:0] mat_mul(input logic [127:0] s, input bit inverse);
    logic [7:0]   b[16];
    logic [127:0] t, r;
    logic [7:0]   acc, k;
    t = s;
    for (int kk = 15; kk >= 0; kk--) begin
      b[4'(kk)] = t[7:0];
      t = t >> 8;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          k = inverse ? inv_k[2'(j - i)] : fwd_k[2'(j - i)];
          acc ^= gf_mul(k, b[4'(4 * c + j)]);
        end
        r = {r[119:0], acc};
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: result compare, 4-cycle latency, hold-under-backpressure.
  initial begin
    logic         prev_ov, prev_or, prev_rst;
    logic [127:0] prev_od;
    int           a;
    prev_ov = 1'b0; prev_or = 1'b0; prev_rst = 1'b1; prev_od = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_ov && !prev_or && !prev_rst) begin
          chk("hold_valid", {127'b0, out_valid}, 128'd1);
          chk("hold_data", out_data, prev_od);
        end
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL latency got out_valid expected no output pending");
          end else begin
            a = acc_q.pop_front();
            chk("latency", 128'(cyc - a), 128'd4);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL result got %h expected no output", out_data);
          end else begin
            chk("result", out_data, exp_q.pop_front());
          end
        end
      end
      prev_ov = out_valid; prev_or = out_ready; prev_rst = rst; prev_od = out_data;
    end
  end

  // Presents d until accepted; leaves in_valid high so the caller can chain.
  task automatic send(input logic [127:0] d, input logic [127:0] e, input bit rnd);
    int unsigned n;
    bit acc;
    n = 0; acc = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 100) begin
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        acc_log.push_back(cyc + 1);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept got in_ready=0 expected accept within 100 cycles");
    end
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [127:0] v, o;
    int unsigned  n, base;
    fwd_k[0] = 8'h02; fwd_k[1] = 8'h03; fwd_k[2] = 8'h01; fwd_k[3] = 8'h01;
    inv_k[0] = 8'h0e; inv_k[1] = 8'h0b; inv_k[2] = 8'h0d; inv_k[3] = 8'h09;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 128'hdb135345_f20a225c_01010101_d4d4d4d5, 0);
    drain();
    send(128'h0, 128'h0, 0);
    drain();
    send({4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}, 0);
    drain();
    send({4{32'h4d7ebdf8}}, {4{32'h2d26314c}}, 0);
    drain();

    // Backpressure with a stray in_valid pulse that must be ignored.
    v = rand128();
    out_ready = 1'b0;
    send(v, mat_mul(v, 1), 0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_reach", {127'b0, out_valid}, 128'd1);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin in_valid = 1'b1; in_data = rand128(); end
      if (k == 4) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_data", out_data, mat_mul(v, 1));
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      @(posedge clk); #1;
    end
    drain();
    repeat (8) @(posedge clk);
    #1;
    chk("bp_no_extra", {127'b0, out_valid}, 128'd0);

    // Reset in the second BUSY cycle.
    v = rand128();
    send(v, mat_mul(v, 1), 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_out_data", out_data, 128'd0);
    @(posedge clk); #1;
    v = rand128();
    send(v, mat_mul(v, 1), 0);
    drain();

    // Back-to-back with in_valid held high.
    base = acc_log.size();
    for (int k = 0; k < 3; k++) begin
      v = rand128();
      send(v, mat_mul(v, 1), 0);
    end
    drain();
    chk("b2b_gap1", 128'(acc_log[base + 1] - acc_log[base]), 128'd6);
    chk("b2b_gap2", 128'(acc_log[base + 2] - acc_log[base + 1]), 128'd6);

    // Round trip through forward MixColumns with random backpressure.
    for (int k = 0; k < 1000; k++) begin
      o = rand128();
      send(mat_mul(o, 0), o, 1);
    end
    drain();

    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", {127'b0, out_valid}, 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
